mem_access_unit: RTL and testbench

Load/store access unit sitting directly downstream of the MEM pipeline stage in the OpenMIPS minimal SOPC, between the core and the data RAM. It accepts one memory request at a time, performs big-endian byte/halfword/word alignment and byte-lane selection, drives a variable-latency RAM handshake with a timeout, and owns the LL/SC link bit and link address. The pipeline stalls while the unit is busy.

---
 rtl/mem_access_unit_pkg.sv | 84 ++++++++
 rtl/mem_access_unit_llsc_monitor.sv | 41 ++++
 rtl/mem_access_unit.sv | 192 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the load/store access unit: opcodes, FSM states,
// big-endian byte-lane selects and small decode helpers.
package mem_access_unit_pkg;

    localparam logic [3:0] OP_LB  = 4'd0;
    localparam logic [3:0] OP_LBU = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LW  = 4'd4;
    localparam logic [3:0] OP_SB  = 4'd5;
    localparam logic [3:0] OP_SH  = 4'd6;
    localparam logic [3:0] OP_SW  = 4'd7;
    localparam logic [3:0] OP_LL  = 4'd8;
    localparam logic [3:0] OP_SC  = 4'd9;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // Lane bit 3 is data[31:24], i.e. byte offset 0 in big-endian order.
    localparam logic [3:0] SEL_B0 = 4'b1000;
    localparam logic [3:0] SEL_B1 = 4'b0100;
    localparam logic [3:0] SEL_B2 = 4'b0010;
    localparam logic [3:0] SEL_B3 = 4'b0001;
    localparam logic [3:0] SEL_H0 = 4'b1100;
    localparam logic [3:0] SEL_H2 = 4'b0011;
    localparam logic [3:0] SEL_W  = 4'b1111;

    typedef enum logic [1:0] {
        SZ_NONE,
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_e;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    function automatic size_e op_size(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB:        return SZ_BYTE;
            OP_LH, OP_LHU, OP_SH:        return SZ_HALF;
            OP_LW, OP_SW, OP_LL, OP_SC:  return SZ_WORD;
            default:                     return SZ_NONE;
        endcase
    endfunction

    function automatic logic is_load(input logic [3:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
               (op == OP_LHU) || (op == OP_LW) || (op == OP_LL);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW) || (op == OP_SC);
    endfunction

    function automatic logic misaligned(input logic [3:0] op, input logic [1:0] off);
        case (op_size(op))
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_sel(input logic [3:0] op, input logic [1:0] off);
        case (op_size(op))
            SZ_BYTE: begin
                case (off)
                    2'd0:    return SEL_B0;
                    2'd1:    return SEL_B1;
                    2'd2:    return SEL_B2;
                    default: return SEL_B3;
                endcase
            end
            SZ_HALF: return off[1] ? SEL_H2 : SEL_H0;
            SZ_WORD: return SEL_W;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_llsc_monitor.sv
// LL/SC link tracking: link bit and word address, with external clear
// taking priority over an LL that completes in the same cycle.
import mem_access_unit_pkg::*;

module llsc_monitor (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        set_i,
    input  logic        sc_done_i,
    input  logic [29:0] set_addr_i,
    input  logic [29:0] chk_addr_i,
    output logic        llbit_o,
    output logic        match_o
);

    logic        llbit_reg;
    logic [29:0] link_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            llbit_reg <= 1'b0;
            link_reg  <= '0;
        end else begin
            if (set_i) begin
                link_reg <= set_addr_i;
            end
            if (clear_i) begin
                llbit_reg <= 1'b0;
            end else if (set_i) begin
                llbit_reg <= 1'b1;
            end else if (sc_done_i) begin
                llbit_reg <= 1'b0;
            end
        end
    end

    assign llbit_o = llbit_reg;
    assign match_o = llbit_reg && (link_reg == chk_addr_i);

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit between the MEM stage and data RAM:
// big-endian lane alignment, variable-latency handshake with timeout, LL/SC.
import mem_access_unit_pkg::*;

module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic [3:0]  op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        llbit_clear_i,
    output logic        ready_o,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        adel_o,
    output logic        ades_o,
    output logic        buserr_o,
    output logic        llbit_o,
    output logic        ram_ce_o,
    output logic        ram_we_o,
    output logic [3:0]  ram_sel_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_data_o,
    input  logic [31:0] ram_data_i,
    input  logic        ram_ack_i
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    logic [1:0]    state_reg, state_next;
    req_t          req_reg, req_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [31:0]   rdata_reg, rdata_next;
    logic          adel_reg, adel_next;
    logic          ades_reg, ades_next;
    logic          buserr_reg, buserr_next;

    logic          ll_set, sc_clr, sc_match;
    logic [7:0]    rd_byte [4];
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;
    logic [31:0]   load_val;
    logic [31:0]   st_data;
    logic          in_access;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rd_byte
            assign rd_byte[gi] = ram_data_i[8*gi +: 8];
        end
    endgenerate

    // Big-endian: byte offset k lives in rd_byte[3-k], and 3-k == ~k for 2 bits.
    assign lane_b = rd_byte[~req_reg.addr[1:0]];
    assign lane_h = req_reg.addr[1] ? ram_data_i[15:0] : ram_data_i[31:16];

    always_comb begin
        load_val = '0;
        case (req_reg.op)
            OP_LB:        load_val = {{24{lane_b[7]}}, lane_b};
            OP_LBU:       load_val = {24'd0, lane_b};
            OP_LH:        load_val = {{16{lane_h[15]}}, lane_h};
            OP_LHU:       load_val = {16'd0, lane_h};
            OP_LW, OP_LL: load_val = ram_data_i;
            OP_SC:        load_val = 32'd1;
            default:      load_val = '0;
        endcase
    end

    always_comb begin
        st_data = '0;
        case (req_reg.op)
            OP_SB:        st_data = {4{req_reg.wdata[7:0]}};
            OP_SH:        st_data = {2{req_reg.wdata[15:0]}};
            OP_SW, OP_SC: st_data = req_reg.wdata;
            default:      st_data = '0;
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        req_next    = req_reg;
        cnt_next    = cnt_reg;
        rdata_next  = rdata_reg;
        adel_next   = adel_reg;
        ades_next   = ades_reg;
        buserr_next = buserr_reg;
        ll_set      = 1'b0;
        sc_clr      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (req_i) begin
                    req_next.op    = op_i;
                    req_next.addr  = addr_i;
                    req_next.wdata = wdata_i;
                    cnt_next       = '0;
                    if (misaligned(op_i, addr_i[1:0])) begin
                        state_next  = ST_RESP;
                        rdata_next  = '0;
                        adel_next   = is_load(op_i);
                        ades_next   = is_store(op_i);
                        buserr_next = 1'b0;
                    end else if (op_size(op_i) == SZ_NONE ||
                                 (op_i == OP_SC && !sc_match)) begin
                        state_next  = ST_RESP;
                        rdata_next  = '0;
                        adel_next   = 1'b0;
                        ades_next   = 1'b0;
                        buserr_next = 1'b0;
                    end else begin
                        state_next = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (ram_ack_i) begin
                    state_next  = ST_RESP;
                    rdata_next  = load_val;
                    adel_next   = 1'b0;
                    ades_next   = 1'b0;
                    buserr_next = 1'b0;
                    ll_set      = (req_reg.op == OP_LL);
                    sc_clr      = (req_reg.op == OP_SC);
                end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
                    state_next  = ST_RESP;
                    rdata_next  = '0;
                    adel_next   = 1'b0;
                    ades_next   = 1'b0;
                    buserr_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= ST_IDLE;
            req_reg    <= '0;
            cnt_reg    <= '0;
            rdata_reg  <= '0;
            adel_reg   <= 1'b0;
            ades_reg   <= 1'b0;
            buserr_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            req_reg    <= req_next;
            cnt_reg    <= cnt_next;
            rdata_reg  <= rdata_next;
            adel_reg   <= adel_next;
            ades_reg   <= ades_next;
            buserr_reg <= buserr_next;
        end
    end

    llsc_monitor u_llsc (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (llbit_clear_i),
        .set_i      (ll_set),
        .sc_done_i  (sc_clr),
        .set_addr_i (req_reg.addr[31:2]),
        .chk_addr_i (addr_i[31:2]),
        .llbit_o    (llbit_o),
        .match_o    (sc_match)
    );

    // RAM-side outputs are decoded from the held request and gated by the
    // state register, so an asynchronous reset drops them immediately.
    assign in_access  = (state_reg == ST_ACCESS);
    assign ram_ce_o   = in_access;
    assign ram_we_o   = in_access && is_store(req_reg.op);
    assign ram_sel_o  = in_access ? lane_sel(req_reg.op, req_reg.addr[1:0]) : 4'b0000;
    assign ram_addr_o = in_access ? {req_reg.addr[31:2], 2'b00} : 32'd0;
    assign ram_data_o = in_access ? st_data : 32'd0;

    assign ready_o  = (state_reg == ST_IDLE);
    assign stall_o  = (req_i && !ready_o) || (state_reg != ST_IDLE);
    assign done_o   = (state_reg == ST_RESP);
    assign rdata_o  = rdata_reg;
    assign adel_o   = adel_reg;
    assign ades_o   = ades_reg;
    assign buserr_o = buserr_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus randomized bench for mem_access_unit against a byte-level
// behavioural model of alignment, lane selection and LL/SC.
module tb_mem_access_unit;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_i = 1'b0;
    logic [3:0]  op_i = '0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        llbit_clear_i = 1'b0;
    logic        ready_o, stall_o, done_o;
    logic [31:0] rdata_o;
    logic        adel_o, ades_o, buserr_o, llbit_o;
    logic        ram_ce_o, ram_we_o;
    logic [3:0]  ram_sel_o;
    logic [31:0] ram_addr_o, ram_data_o;
    logic [31:0] ram_data_i = '0;
    logic        ram_ack_i = 1'b0;

    int checks = 0;
    int failures = 0;

    logic        m_llbit = 1'b0;
    logic [29:0] m_link = '0;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .op_i(op_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .llbit_clear_i(llbit_clear_i), .ready_o(ready_o),
        .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o), .adel_o(adel_o),
        .ades_o(ades_o), .buserr_o(buserr_o), .llbit_o(llbit_o),
        .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_sel_o(ram_sel_o),
        .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
        .ram_data_i(ram_data_i), .ram_ack_i(ram_ack_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int op_bytes(input logic [3:0] op);
        case (op)
            4'd0, 4'd1, 4'd5:       return 1;
            4'd2, 4'd3, 4'd6:       return 2;
            4'd4, 4'd7, 4'd8, 4'd9: return 4;
            default:                return 0;
        endcase
    endfunction

    function automatic logic op_loads(input logic [3:0] op);
        return op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8};
    endfunction

    function automatic logic op_stores(input logic [3:0] op);
        return op inside {4'd5, 4'd6, 4'd7, 4'd9};
    endfunction

    // ack_dly: ACCESS cycles before ack (0 = same cycle as ce); negative = never ack.
    task automatic txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input int ack_dly, input logic [31:0] word, input logic clr);
        int          sz, off, cyc, exp_lat;
        logic        mis, early, never, got;
        logic [3:0]  exp_sel;
        logic [31:0] exp_wd, exp_rd, f, mask;
        sz    = op_bytes(op);
        off   = int'(addr[1:0]);
        mis   = (sz > 0) && ((off % sz) != 0);
        early = (sz == 0) || mis || (op == 4'd9 && !(m_llbit && m_link == addr[31:2]));
        never = (ack_dly < 0);
        exp_sel = '0;
        exp_wd  = '0;
        for (int b = 0; b < 4; b++) begin
            if (sz > 0 && b >= off && b < off + sz) exp_sel[3-b] = 1'b1;
            if (op_stores(op) && sz > 0) exp_wd[31-8*b -: 8] = wdata[8*(sz-1-(b % sz)) +: 8];
        end
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*sz)) - 32'd1);
        f = (sz > 0 && !mis) ? ((word >> (8*(4-off-sz))) & mask) : 32'd0;
        if ((op == 4'd0 || op == 4'd2) && f[8*sz-1]) f = f | ~mask;
        exp_lat = early ? 1 : (never ? TO + 1 : ack_dly + 2);
        exp_rd  = (early || never) ? 32'd0 : (op == 4'd9 ? 32'd1 : (op_loads(op) ? f : 32'd0));

        @(negedge clk);
        check("ready_idle", {31'd0, ready_o}, 32'd1);
        check("stall_idle", {31'd0, stall_o}, 32'd0);
        op_i = op; addr_i = addr; wdata_i = wdata; req_i = 1'b1;
        @(posedge clk);
        #1;
        req_i = 1'b0; op_i = '0; addr_i = '0; wdata_i = '0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 60) begin
            @(negedge clk);
            cyc++;
            ram_ack_i = 1'b0;
            llbit_clear_i = 1'b0;
            if (done_o) begin
                got = 1'b1;
            end else begin
                if (cyc == 1) begin
                    check("ce", {31'd0, ram_ce_o}, {31'd0, !early});
                    check("ready_busy", {31'd0, ready_o}, 32'd0);
                    check("stall_busy", {31'd0, stall_o}, 32'd1);
                    if (!early) begin
                        check("sel", {28'd0, ram_sel_o}, {28'd0, exp_sel});
                        check("we", {31'd0, ram_we_o}, {31'd0, op_stores(op)});
                        check("ram_addr", ram_addr_o, {addr[31:2], 2'b00});
                        check("ram_data", ram_data_o, exp_wd);
                    end
                end
                if (ram_ce_o && !never && cyc == ack_dly + 1) begin
                    ram_ack_i = 1'b1;
                    ram_data_i = word;
                    llbit_clear_i = clr;
                end
            end
        end
        check("latency", 32'(cyc), 32'(exp_lat));
        check("rdata", rdata_o, exp_rd);
        check("adel", {31'd0, adel_o}, {31'd0, mis && op_loads(op)});
        check("ades", {31'd0, ades_o}, {31'd0, mis && op_stores(op)});
        check("buserr", {31'd0, buserr_o}, {31'd0, !early && never});
        check("ce_done", {31'd0, ram_ce_o}, 32'd0);
        if (!early && !never) begin
            if (op == 4'd8) begin
                m_link  = addr[31:2];
                m_llbit = !clr;
            end else if (op == 4'd9 || clr) begin
                m_llbit = 1'b0;
            end
        end
        check("llbit", {31'd0, llbit_o}, {31'd0, m_llbit});
        $display("txn op=%0d addr=%08h wdata=%08h lat=%0d rdata=%08h adel=%b ades=%b buserr=%b llbit=%b",
                 op, addr, wdata, cyc, rdata_o, adel_o, ades_o, buserr_o, llbit_o);
    endtask

    task automatic clear_pulse();
        @(negedge clk);
        llbit_clear_i = 1'b1;
        @(negedge clk);
        llbit_clear_i = 1'b0;
        m_llbit = 1'b0;
        check("llbit_clear", {31'd0, llbit_o}, 32'd0);
        $display("txn llbit_clear llbit=%b", llbit_o);
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] raddr;
        int          rdly;

        #12;
        check("rst_ready", {31'd0, ready_o}, 32'd1);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_ce", {31'd0, ram_ce_o}, 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_llbit", {31'd0, llbit_o}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        txn(4'd0, 32'h03, 32'h0, 1, 32'h1122_3380, 1'b0);
        txn(4'd1, 32'h03, 32'h0, 1, 32'h1122_3380, 1'b0);
        txn(4'd2, 32'h0A, 32'h0, 0, 32'h12_34_95_67, 1'b0);
        txn(4'd3, 32'h08, 32'h0, 2, 32'hABCD_1234, 1'b0);
        txn(4'd6, 32'h102, 32'hBEEF, 0, 32'h0, 1'b0);
        txn(4'd5, 32'h201, 32'h12A5, 0, 32'h0, 1'b0);
        txn(4'd4, 32'h06, 32'h0, 0, 32'h0, 1'b0);
        txn(4'd7, 32'h05, 32'h0, 0, 32'h0, 1'b0);
        txn(4'd8, 32'h40, 32'h0, 0, 32'hCAFE_F00D, 1'b0);
        txn(4'd9, 32'h40, 32'h5, 0, 32'h0, 1'b0);
        txn(4'd9, 32'h40, 32'h5, 0, 32'h0, 1'b0);
        txn(4'd8, 32'h40, 32'h0, 1, 32'h0, 1'b0);
        clear_pulse();
        txn(4'd9, 32'h40, 32'h5, 0, 32'h0, 1'b0);
        txn(4'd8, 32'h40, 32'h0, 0, 32'h0, 1'b1);
        txn(4'd8, 32'h44, 32'h0, 0, 32'h0, 1'b0);
        txn(4'd9, 32'h48, 32'h7, 0, 32'h0, 1'b0);
        txn(4'd9, 32'h44, 32'h7, -1, 32'h0, 1'b0);
        txn(4'd8, 32'h80, 32'h0, -1, 32'h0, 1'b0);
        txn(4'd4, 32'h80, 32'h0, -1, 32'h0, 1'b0);
        txn(4'd12, 32'h10, 32'h0, 0, 32'h0, 1'b0);

        // Asynchronous reset in the middle of an access.
        txn(4'd8, 32'h60, 32'h0, 0, 32'h8000_0001, 1'b0);
        @(negedge clk);
        op_i = 4'd4; addr_i = 32'h20; req_i = 1'b1;
        @(posedge clk);
        #1;
        req_i = 1'b0; op_i = '0; addr_i = '0;
        @(negedge clk);
        check("mid_ce", {31'd0, ram_ce_o}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("arst_ce", {31'd0, ram_ce_o}, 32'd0);
        check("arst_ready", {31'd0, ready_o}, 32'd1);
        check("arst_stall", {31'd0, stall_o}, 32'd0);
        check("arst_sel", {28'd0, ram_sel_o}, 32'd0);
        check("arst_addr", ram_addr_o, 32'd0);
        check("arst_rdata", rdata_o, 32'd0);
        check("arst_llbit", {31'd0, llbit_o}, 32'd0);
        m_llbit = 1'b0;
        m_link  = '0;
        $display("txn async_reset ce=%b ready=%b llbit=%b", ram_ce_o, ready_o, llbit_o);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 60; i++) begin
            rop   = 4'($urandom_range(0, 11));
            raddr = 32'(($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) raddr[1:0] = 2'b00;
            rdly  = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
            txn(rop, raddr, $urandom, rdly, $urandom, ($urandom_range(0, 7) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
